// File: rtl/memory_request_arbiter_if.sv
// Channel-side and memory-side bundles of the memory request arbiter.
// master: arbiter view; slave: requesters plus memory controller view.
interface memory_request_arbiter_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_address;
  logic [NUM_CH*DATA_W-1:0] ch_write_data;
  logic [NUM_CH-1:0]        ch_resp_valid;
  logic [NUM_CH-1:0]        ch_resp_ready;
  logic                     ch_resp_error;
  logic [DATA_W-1:0]        ch_resp_read_data;
  logic                     mem_valid;
  logic                     mem_ready;
  logic                     mem_write;
  logic [ADDR_W-1:0]        mem_address;
  logic [DATA_W-1:0]        mem_write_data;
  logic                     mem_resp_valid;
  logic                     mem_resp_error;
  logic [DATA_W-1:0]        mem_resp_read_data;

  modport master (
    input  ch_valid, ch_write, ch_address,
    input  ch_write_data, ch_resp_ready,
    input  mem_ready, mem_resp_valid,
    input  mem_resp_error, mem_resp_read_data,
    output ch_ready, ch_resp_valid,
    output ch_resp_error, ch_resp_read_data,
    output mem_valid, mem_write,
    output mem_address, mem_write_data
  );

  modport slave (
    output ch_valid, ch_write, ch_address,
    output ch_write_data, ch_resp_ready,
    output mem_ready, mem_resp_valid,
    output mem_resp_error, mem_resp_read_data,
    input  ch_ready, ch_resp_valid,
    input  ch_resp_error, ch_resp_read_data,
    input  mem_valid, mem_write,
    input  mem_address, mem_write_data
  );
endinterface

// File: rtl/memory_request_arbiter.sv
// Round-robin arbiter: NUM_CH requesters share one memory port.
// Ports: clock, clear_n (async low), bus (master), timeout_count.
module memory_request_arbiter #(
  parameter int NUM_CH         = 3,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clock,
  input  logic                     clear_n,
  memory_request_arbiter_if.master bus,
  output logic [15:0]              timeout_count
);
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] LAST   = GW'(NUM_CH - 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT_RESP, RESPOND
  } state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     last_q, last_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [15:0]       tcnt_q, tcnt_d;

  logic              found;
  logic [GW-1:0]     pick;
  logic [GW-1:0]     idx;

  // Scan starts one past the last grant and wraps.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = GW'((int'(last_q) + k) % NUM_CH);
      if (!found && bus.ch_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    tcnt_d  = tcnt_q;
    bus.ch_ready      = '0;
    bus.ch_resp_valid = '0;
    bus.mem_valid     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          // ready is combinational; mask it while reset is held
          bus.ch_ready[pick] = clear_n;
          grant_d = pick;
          wr_d    = bus.ch_write[pick];
          addr_d  =
            bus.ch_address[int'(pick)*ADDR_W +: ADDR_W];
          wdata_d =
            bus.ch_write_data[int'(pick)*DATA_W +: DATA_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_valid = 1'b1;
        if (bus.mem_ready) begin
          wdog_d  = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        wdog_d = wdog_q + 1'b1;
        // a real response beats a coincident timeout
        if (bus.mem_resp_valid) begin
          err_d   = bus.mem_resp_error;
          rdata_d = (wr_q || bus.mem_resp_error)
                  ? '0 : bus.mem_resp_read_data;
          state_d = RESPOND;
        end else if (wdog_q == WD_MAX) begin
          err_d   = 1'b1;
          rdata_d = '0;
          if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        bus.ch_resp_valid[grant_q] = 1'b1;
        if (bus.ch_resp_ready[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      last_q  <= LAST;
      grant_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign bus.mem_write         = wr_q;
  assign bus.mem_address       = addr_q;
  assign bus.mem_write_data    = wdata_q;
  assign bus.ch_resp_error     = err_q;
  assign bus.ch_resp_read_data = rdata_q;
  assign timeout_count         = tcnt_q;
endmodule

// File: tb/tb_memory_request_arbiter.sv
// Directed bench for the round-robin memory request arbiter.
// Drives after posedge, samples combinational/registered outputs mid-cycle.
module tb_memory_request_arbiter;
  localparam int NCH = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TO  = 8;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic [15:0] timeout_count;
  int          n_chk = 0;
  int          n_err = 0;
  logic [2:0]  ord [3];
  logic [2:0]  exp_g;
  int          j;
  int          p;

  memory_request_arbiter_if #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)
  ) bus ();

  memory_request_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .clear_n(clear_n),
    .bus(bus.master),
    .timeout_count(timeout_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int i, input logic wr,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    bus.ch_write[i]               = wr;
    bus.ch_address[i*AW +: AW]    = a;
    bus.ch_write_data[i*DW +: DW] = d;
  endtask

  initial begin
    ord[0] = 3'b001;
    ord[1] = 3'b010;
    ord[2] = 3'b100;
    bus.ch_valid           = '0;
    bus.ch_write           = '0;
    bus.ch_address         = '0;
    bus.ch_write_data      = '0;
    bus.ch_resp_ready      = '0;
    bus.mem_ready          = 1'b0;
    bus.mem_resp_valid     = 1'b0;
    bus.mem_resp_error     = 1'b0;
    bus.mem_resp_read_data = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", bus.ch_ready, 0);
    check("rst_mvalid", bus.mem_valid, 0);
    check("rst_rvalid", bus.ch_resp_valid, 0);
    check("rst_tcnt", timeout_count, 0);
    check("rst_maddr", bus.mem_address, 0);
    check("rst_err", bus.ch_resp_error, 0);
    @(negedge clock);
    clear_n = 1'b1;

    // single read on ch0
    cyc();
    set_ch(0, 1'b0, 32'h100, 32'h0);
    bus.ch_valid = 3'b001;
    #1;
    check("t1_ready", bus.ch_ready, 3'b001);
    cyc();
    bus.ch_valid  = '0;
    bus.mem_ready = 1'b1;
    #1;
    check("t1_mvalid", bus.mem_valid, 1);
    check("t1_maddr", bus.mem_address, 32'h100);
    check("t1_mwrite", bus.mem_write, 0);
    cyc();
    bus.mem_ready          = 1'b0;
    bus.mem_resp_valid     = 1'b1;
    bus.mem_resp_read_data = 32'hDEADBEEF;
    #1;
    check("t1_early", bus.ch_resp_valid, 0);
    cyc();
    bus.mem_resp_valid = 1'b0;
    bus.ch_resp_ready  = 3'b001;
    #1;
    check("t1_rvalid", bus.ch_resp_valid, 3'b001);
    check("t1_rdata", bus.ch_resp_read_data, 32'hDEADBEEF);
    check("t1_err", bus.ch_resp_error, 0);
    cyc();
    bus.ch_resp_ready = '0;
    #1;
    check("t1_done", bus.ch_resp_valid, 0);

    // all channels valid from reset
    clear_n = 1'b0;
    #1;
    @(negedge clock);
    clear_n = 1'b1;
    set_ch(0, 1'b0, 32'h10, 32'h0);
    set_ch(1, 1'b1, 32'h20, 32'h77);
    set_ch(2, 1'b0, 32'h30, 32'h0);
    bus.mem_ready          = 1'b1;
    bus.mem_resp_valid     = 1'b1;
    bus.mem_resp_error     = 1'b0;
    bus.mem_resp_read_data = 32'h5A5A0000;
    bus.ch_resp_ready      = '1;
    cyc();
    bus.ch_valid = '1;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) cyc();
      #1;
      j = i / 4;
      p = i % 4;
      exp_g = ord[j % 3];
      check("t2_onehot",
            64'($countones(bus.ch_ready) <= 1), 1);
      if (p == 0)
        check("t2_grant", bus.ch_ready, exp_g);
      if (p == 1) begin
        check("t2_maddr", bus.mem_address,
              64'(32'h10 * (j % 3 + 1)));
        check("t2_mwrite", bus.mem_write,
              64'(j % 3 == 1));
      end
      if (p == 2)
        check("t2_wait", bus.ch_resp_valid, 0);
      if (p == 3) begin
        check("t2_rvalid", bus.ch_resp_valid, exp_g);
        check("t2_rdata", bus.ch_resp_read_data,
              (j % 3 == 1) ? 64'h0 : 64'h5A5A0000);
      end
    end

    // wrap-around: last grant 2, ch0 and ch1 valid
    cyc();
    bus.ch_valid = 3'b011;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      #1;
      j = i / 4;
      p = i % 4;
      exp_g = ord[j];
      if (p == 0)
        check("t3_grant", bus.ch_ready, exp_g);
      if (p == 1)
        check("t3_maddr", bus.mem_address,
              64'(32'h10 * (j + 1)));
      if (p == 3)
        check("t3_rvalid", bus.ch_resp_valid, exp_g);
    end
    cyc();
    bus.ch_valid       = '0;
    bus.mem_resp_valid = 1'b0;
    bus.ch_resp_ready  = '0;
    #1;
    check("t3_idle", bus.ch_ready, 0);

    // watchdog timeout on ch2
    cyc();
    set_ch(2, 1'b0, 32'h300, 32'h0);
    bus.ch_valid = 3'b100;
    #1;
    check("t4_ready", bus.ch_ready, 3'b100);
    cyc();
    bus.ch_valid = '0;
    #1;
    check("t4_mvalid", bus.mem_valid, 1);
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    check("t4_tcnt0", timeout_count, 0);
    for (int i = 1; i < TO; i++) begin
      cyc();
      #1;
      check("t4_wait", bus.ch_resp_valid, 0);
    end
    cyc();
    bus.mem_resp_valid     = 1'b1;
    bus.mem_resp_read_data = 32'h1111;
    #1;
    check("t4_rvalid", bus.ch_resp_valid, 3'b100);
    check("t4_err", bus.ch_resp_error, 1);
    check("t4_rdata", bus.ch_resp_read_data, 0);
    check("t4_tcnt1", timeout_count, 1);
    cyc();
    bus.mem_resp_valid = 1'b0;
    bus.ch_resp_ready  = 3'b100;
    #1;
    check("t4_late_v", bus.ch_resp_valid, 3'b100);
    check("t4_late_d", bus.ch_resp_read_data, 0);
    check("t4_late_e", bus.ch_resp_error, 1);
    check("t4_late_t", timeout_count, 1);
    cyc();
    bus.ch_resp_ready  = '0;
    bus.mem_resp_valid = 1'b1;
    #1;
    check("t4_idle", bus.ch_resp_valid, 0);
    cyc();
    bus.mem_resp_valid = 1'b0;
    #1;
    check("t4_stray_v", bus.ch_resp_valid, 0);
    check("t4_stray_t", timeout_count, 1);

    // response back-pressure on ch1 write
    cyc();
    set_ch(1, 1'b1, 32'h200, 32'hCAFE);
    bus.ch_valid = 3'b010;
    #1;
    check("t5_ready", bus.ch_ready, 3'b010);
    cyc();
    bus.ch_valid  = 3'b001;
    bus.mem_ready = 1'b1;
    #1;
    check("t5_mvalid", bus.mem_valid, 1);
    check("t5_mwrite", bus.mem_write, 1);
    check("t5_maddr", bus.mem_address, 32'h200);
    check("t5_mwdata", bus.mem_write_data, 32'hCAFE);
    check("t5_noready", bus.ch_ready, 0);
    cyc();
    bus.mem_ready          = 1'b0;
    bus.mem_resp_valid     = 1'b1;
    bus.mem_resp_error     = 1'b1;
    bus.mem_resp_read_data = 32'h1234;
    #1;
    cyc();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_error = 1'b0;
    bus.ch_resp_ready  = 3'b101;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        cyc();
        #1;
      end
      check("t5_rvalid", bus.ch_resp_valid, 3'b010);
      check("t5_err", bus.ch_resp_error, 1);
      check("t5_rdata", bus.ch_resp_read_data, 0);
      check("t5_hold", bus.ch_ready, 0);
    end
    cyc();
    bus.ch_resp_ready = 3'b010;
    #1;
    check("t5_last", bus.ch_resp_valid, 3'b010);
    cyc();
    bus.ch_resp_ready = '0;
    #1;
    check("t5_next", bus.ch_ready, 3'b001);
    check("t5_idle", bus.ch_resp_valid, 0);

    // async reset during WAIT_RESP
    cyc();
    bus.ch_valid  = '0;
    bus.mem_ready = 1'b1;
    #1;
    check("t6_mvalid", bus.mem_valid, 1);
    cyc();
    bus.mem_ready = 1'b0;
    bus.ch_valid  = 3'b111;
    #1;
    cyc();
    #2;
    clear_n = 1'b0;
    #1;
    check("t6_r_mv", bus.mem_valid, 0);
    check("t6_r_rv", bus.ch_resp_valid, 0);
    check("t6_r_rdy", bus.ch_ready, 0);
    check("t6_r_tcnt", timeout_count, 0);
    check("t6_r_err", bus.ch_resp_error, 0);
    check("t6_r_addr", bus.mem_address, 0);
    #2;
    clear_n = 1'b1;
    #1;
    check("t6_first", bus.ch_ready, 3'b001);
    check("t6_nostale", bus.ch_resp_valid, 0);
    cyc();
    bus.ch_valid = '0;
    #1;
    check("t6_mvalid2", bus.mem_valid, 1);
    check("t6_maddr", bus.mem_address, 32'h10);
    for (int i = 0; i < 2; i++) begin
      cyc();
      #1;
      check("t6_quiet", bus.ch_resp_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
